// File: rtl/ram_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// single clock, with an optional post-reset clear sweep flagged by init_busy.
module ram_sdp #(
    parameter int addr_width     = 9,
    parameter int data_width     = 128,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [data_width-1:0] INIT_VALUE = '0,
    parameter int RDW_NEW        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] din,
    input  logic                  write_en,
    input  logic [addr_width-1:0] waddr,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] dout,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** addr_width;
    localparam logic [addr_width:0] LAST_ADDR = (addr_width + 1)'(DEPTH - 1);

    logic [data_width-1:0] mem_q [DEPTH];
    logic [addr_width:0]   cnt_q;
    logic                  busy_q;
    logic [data_width-1:0] dout_q;

    logic                  sweep_en;
    logic                  wr_acc;
    logic                  mem_we;
    logic [addr_width-1:0] mem_wa;
    logic [data_width-1:0] mem_wd;
    logic [data_width-1:0] rd_data_d;

    // The sweep borrows the single write port; user writes are dropped while busy.
    assign sweep_en = rst && busy_q && (CLEAR_ON_RESET != 0);
    assign wr_acc   = rst && !busy_q && write_en;
    assign mem_we   = sweep_en || wr_acc;
    assign mem_wa   = sweep_en ? cnt_q[addr_width-1:0] : waddr;
    assign mem_wd   = sweep_en ? INIT_VALUE : din;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        rd_data_d = mem_q[raddr];
        if ((RDW_NEW != 0) && wr_acc && (raddr == waddr)) begin
            rd_data_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= '0;
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (CLEAR_ON_RESET != 0) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    busy_q <= 1'b0;
                end
            end else begin
                busy_q <= 1'b0;
            end
        end else begin
            dout_q <= rd_data_d;
        end
    end

    assign dout      = dout_q;
    assign init_busy = busy_q;

endmodule

// File: tb/tb_ram_sdp.sv
// Directed bench for ram_sdp: old-data and bypass instances share stimulus and a
// behavioural memory model; a third instance covers the no-clear configuration.
module tb_ram_sdp;

    localparam int AW = 4;
    localparam int DW = 128;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          busy;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          rst2;
    logic [DW-1:0] din;
    logic          write_en;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] dout0, dout1, dout2;
    logic          busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_busy = 1'b1;
    int            m_cnt  = 0;

    ram_sdp #(.addr_width(AW), .data_width(DW), .CLEAR_ON_RESET(1), .INIT_VALUE('0), .RDW_NEW(0)) u_old (
        .clk(clk), .rst(rst), .din(din), .write_en(write_en), .waddr(waddr),
        .raddr(raddr), .dout(dout0), .init_busy(busy0));

    ram_sdp #(.addr_width(AW), .data_width(DW), .CLEAR_ON_RESET(1), .INIT_VALUE('0), .RDW_NEW(1)) u_new (
        .clk(clk), .rst(rst), .din(din), .write_en(write_en), .waddr(waddr),
        .raddr(raddr), .dout(dout1), .init_busy(busy1));

    ram_sdp #(.addr_width(AW), .data_width(DW), .CLEAR_ON_RESET(0), .INIT_VALUE('0), .RDW_NEW(0)) u_noclr (
        .clk(clk), .rst(rst2), .din(din), .write_en(write_en), .waddr(waddr),
        .raddr(raddr), .dout(dout2), .init_busy(busy2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, push the model's expectation, pop and compare after the edge.
    task automatic cyc(input logic r, input logic we, input int wa, input logic [DW-1:0] d, input int ra);
        exp_t e;
        logic [AW-1:0] a_w;
        logic [AW-1:0] a_r;
        a_w = wa[AW-1:0];
        a_r = ra[AW-1:0];
        rst = r; write_en = we; waddr = a_w; din = d; raddr = a_r;
        if (!r) begin
            e.d0 = '0; e.d1 = '0; e.busy = 1'b1;
            m_busy = 1'b1; m_cnt = 0;
        end else if (m_busy) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            m_busy = (m_cnt != DEPTH);
            e.d0 = '0; e.d1 = '0; e.busy = m_busy;
        end else begin
            e.d0 = m_mem[a_r];
            e.d1 = (we && a_w == a_r) ? d : m_mem[a_r];
            if (we) m_mem[a_w] = d;
            e.busy = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("dout_old", dout0, e.d0);
        chk("dout_new", dout1, e.d1);
        chk("busy_old", {127'b0, busy0}, {127'b0, e.busy});
        chk("busy_new", {127'b0, busy1}, {127'b0, e.busy});
    endtask

    localparam logic [DW-1:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        int rel_cycles;
        clk = 1'b0; rst = 1'b0; rst2 = 1'b0;
        din = '0; write_en = 1'b0; waddr = '0; raddr = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // reset for three cycles, then the sweep; count cycles until busy drops
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, '0, 0);
        rel_cycles = 0;
        for (int i = 0; i < DEPTH + 4 && busy0; i++) begin
            cyc(1'b1, 1'b0, 0, '0, 0);
            rel_cycles++;
        end
        chk("sweep_len", 128'(rel_cycles), 128'(DEPTH));

        // every address reads back the clear value
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 0, '0, i);

        // basic write/read
        cyc(1'b1, 1'b1, 5, PAT, 0);
        cyc(1'b1, 1'b1, 6, PAT + 1, 0);
        cyc(1'b1, 1'b0, 0, '0, 5);
        chk("basic_a5", dout0, PAT);
        cyc(1'b1, 1'b0, 0, '0, 6);
        chk("basic_a6", dout0, PAT + 1);

        // read-during-write on address 3
        cyc(1'b1, 1'b1, 3, 128'hAA, 0);
        cyc(1'b1, 1'b1, 3, 128'hBB, 3);
        chk("rdw_old", dout0, 128'hAA);
        chk("rdw_new", dout1, 128'hBB);
        cyc(1'b1, 1'b0, 0, '0, 3);
        chk("rdw_after", dout0, 128'hBB);

        // streaming write with the read one cycle behind, across the wrap
        for (int i = 0; i < DEPTH + 4; i++) cyc(1'b1, 1'b1, i % DEPTH, 128'(i + 1), (i + DEPTH - 1) % DEPTH);

        // writes during the sweep are dropped; reset mid-sweep restarts it
        cyc(1'b0, 1'b0, 0, '0, 0);
        cyc(1'b0, 1'b0, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1, 128'hFF, 0);
        cyc(1'b0, 1'b1, 1, 128'hFF, 0);
        rel_cycles = 0;
        for (int i = 0; i < DEPTH + 4 && busy0; i++) begin
            cyc(1'b1, 1'b1, 0, 128'hEE, 0);
            rel_cycles++;
        end
        chk("resweep_len", 128'(rel_cycles), 128'(DEPTH));
        cyc(1'b1, 1'b0, 0, '0, 1);
        chk("busy_wr_a1", dout0, '0);
        cyc(1'b1, 1'b0, 0, '0, 0);
        chk("busy_wr_a0", dout0, '0);

        // no-clear instance: one-cycle release, contents survive reset
        chk("noclr_rst_busy", {127'b0, busy2}, 128'd1);
        chk("noclr_rst_dout", dout2, '0);
        rst2 = 1'b1;
        cyc(1'b1, 1'b0, 0, '0, 0);
        chk("noclr_release", {127'b0, busy2}, 128'd0);
        cyc(1'b1, 1'b1, 2, 128'h55, 0);
        rst2 = 1'b0;
        cyc(1'b1, 1'b0, 0, '0, 2);
        chk("noclr_rst2_busy", {127'b0, busy2}, 128'd1);
        chk("noclr_rst2_dout", dout2, '0);
        rst2 = 1'b1;
        cyc(1'b1, 1'b0, 0, '0, 2);
        chk("noclr_release2", {127'b0, busy2}, 128'd0);
        cyc(1'b1, 1'b0, 0, '0, 2);
        chk("noclr_keep_a2", dout2, 128'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
